// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave
//   AXI4 slave terminating a link in an on-chip word-addressed RAM. Serves one
//   burst at a time (no outstanding transactions; reads and writes never
//   overlap). FIXED and INCR bursts are supported. WRAP bursts and a size other
//   than the full bus width get SLVERR, but every beat is still exchanged.
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   s_axi_aw*       write address channel (lock/cache/prot/qos/region/user ignored)
//   s_axi_w*        write data channel (wid/wuser ignored)
//   s_axi_b*        write response channel (buser tied 0)
//   s_axi_ar*       read address channel (lock/cache/prot/qos/region/user ignored)
//   s_axi_r*        read data channel (ruser tied 0)
module axi4_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024,
  localparam int STRB      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic [3:0]            s_axi_awregion,
  input  logic                  s_axi_awuser,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [ID_WIDTH-1:0]   s_axi_wid,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB-1:0]       s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wuser,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_buser,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic [3:0]            s_axi_arregion,
  input  logic                  s_axi_aruser,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_ruser,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int LSB = $clog2(STRB);
  localparam int IW  = $clog2(MEM_DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_DATA = 2'd1;
  localparam logic [1:0] WR_RESP = 2'd2;
  localparam logic [1:0] RD_DATA = 2'd3;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] B_FIXED = 2'b00;
  localparam logic [1:0] B_WRAP  = 2'b10;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [1:0]    state;
  logic          prio;      // 0: write wins a tie, 1: read wins
  logic          en;        // low for the first cycle out of reset
  logic [IW-1:0] idx;
  logic [7:0]    len, cnt;
  logic          fixed, err, wl_err;

  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_awregion, s_axi_awuser, s_axi_arlock, s_axi_arcache,
                       s_axi_arprot, s_axi_arqos, s_axi_arregion, s_axi_aruser,
                       s_axi_wid, s_axi_wuser, s_axi_awaddr, s_axi_araddr};

  logic idle_en, hs_aw, hs_ar, hs_w, hs_r, last_beat, aw_err, ar_err;
  logic [IW-1:0] aw_idx, ar_idx, nidx;

  assign idle_en = en && (state == IDLE);
  assign s_axi_awready = idle_en && s_axi_awvalid && (!prio || !s_axi_arvalid);
  assign s_axi_arready = idle_en && s_axi_arvalid && !s_axi_awready &&
                         (prio || !s_axi_awvalid);
  assign s_axi_wready  = (state == WR_DATA);
  assign s_axi_bvalid  = (state == WR_RESP);
  assign s_axi_buser   = 1'b0;
  assign s_axi_ruser   = 1'b0;

  assign hs_aw = s_axi_awvalid && s_axi_awready;
  assign hs_ar = s_axi_arvalid && s_axi_arready;
  assign hs_w  = s_axi_wvalid  && s_axi_wready;
  assign hs_r  = s_axi_rvalid  && s_axi_rready;

  assign aw_idx = s_axi_awaddr[LSB +: IW];
  assign ar_idx = s_axi_araddr[LSB +: IW];
  assign aw_err = (s_axi_awburst == B_WRAP) || (s_axi_awsize != 3'(LSB));
  assign ar_err = (s_axi_arburst == B_WRAP) || (s_axi_arsize != 3'(LSB));
  assign nidx   = fixed ? idx : idx + IW'(1);
  assign last_beat = (cnt == len);

  // The next read beat is fetched in the same cycle the current one is taken,
  // so back-to-back beats come out with no bubble.
  logic          rd_ld, rd_zero;
  logic [IW-1:0] rd_addr;
  assign rd_ld   = hs_ar || (hs_r && !s_axi_rlast);
  assign rd_addr = hs_ar ? ar_idx : nidx;
  assign rd_zero = hs_ar ? ar_err : err;

  // RAM port: contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (hs_w && !err)
      for (int b = 0; b < STRB; b++)
        if (s_axi_wstrb[b]) mem[idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
    if (rd_ld) s_axi_rdata <= rd_zero ? '0 : mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;  prio <= 1'b0;  en <= 1'b0;
      idx <= '0;  len <= '0;  cnt <= '0;
      fixed <= 1'b0;  err <= 1'b0;  wl_err <= 1'b0;
      s_axi_bid <= '0;  s_axi_bresp <= OKAY;
      s_axi_rid <= '0;  s_axi_rresp <= OKAY;
      s_axi_rvalid <= 1'b0;  s_axi_rlast <= 1'b0;
    end else begin
      en <= 1'b1;
      case (state)
        IDLE: begin
          if (hs_aw) begin
            state <= WR_DATA;
            idx <= aw_idx;  len <= s_axi_awlen;  cnt <= '0;
            fixed <= (s_axi_awburst == B_FIXED);
            err <= aw_err;  wl_err <= 1'b0;
            s_axi_bid <= s_axi_awid;
          end else if (hs_ar) begin
            state <= RD_DATA;
            idx <= ar_idx;  len <= s_axi_arlen;  cnt <= '0;
            fixed <= (s_axi_arburst == B_FIXED);
            err <= ar_err;
            s_axi_rid    <= s_axi_arid;
            s_axi_rresp  <= ar_err ? SLVERR : OKAY;
            s_axi_rvalid <= 1'b1;
            s_axi_rlast  <= (s_axi_arlen == 8'd0);
          end
        end
        WR_DATA: begin
          if (hs_w) begin
            idx <= nidx;
            cnt <= cnt + 8'd1;
            // Length comes from awlen; wlast only affects the response.
            if (last_beat) begin
              state <= WR_RESP;
              s_axi_bresp <= (err || wl_err || !s_axi_wlast) ? SLVERR : OKAY;
            end else if (s_axi_wlast) begin
              wl_err <= 1'b1;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            state <= IDLE;
            prio  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (hs_r) begin
            if (s_axi_rlast) begin
              state <= IDLE;
              prio  <= 1'b0;
              s_axi_rvalid <= 1'b0;
              s_axi_rlast  <= 1'b0;
            end else begin
              idx <= nidx;
              cnt <= cnt + 8'd1;
              s_axi_rlast <= (cnt + 8'd1 == len);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Directed bench for axi4_mem_slave (32-bit data, 1024-word RAM).
module tb_axi4_mem_slave;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  awid, arid, wid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready, buser;
  logic arvalid, arready, rlast, rvalid, rready, ruser;

  axi4_mem_slave dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
    .s_axi_awregion(4'h0), .s_axi_awuser(1'b0), .s_axi_awvalid(awvalid),
    .s_axi_awready(awready),
    .s_axi_wid(wid), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wuser(1'b0), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_buser(buser),
    .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
    .s_axi_arregion(4'h0), .s_axi_aruser(1'b0), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_ruser(ruser), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int n_cmp = 0, n_err = 0;
  logic [31:0] wbuf [256];
  logic [31:0] rbuf [256];
  logic [1:0]  rrsp [256];
  int aw_wait, ar_wait, beats, last_at, nlast, nstall, stall_bad, gaps, lat, ok;
  logic post_rv;
  logic [3:0] rid_got, b_id;
  logic [1:0] b_resp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic aw_go(input logic [3:0] id, input logic [31:0] addr, input int len,
                       input logic [1:0] burst, input logic [2:0] size);
    awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awsize = size;
    awvalid = 1'b1; aw_wait = 0;
    @(negedge clk);
    while (!awready && aw_wait < 50) begin aw_wait++; @(negedge clk); end
    if (!awready) chk("aw_hs_timeout", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic ar_go(input logic [3:0] id, input logic [31:0] addr, input int len,
                       input logic [1:0] burst, input logic [2:0] size);
    arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arsize = size;
    arvalid = 1'b1; ar_wait = 0;
    @(negedge clk);
    while (!arready && ar_wait < 50) begin ar_wait++; @(negedge clk); end
    if (!arready) chk("ar_hs_timeout", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic w_go(input int nb, input int last_idx, input logic [3:0] strb, input bit gap);
    int n;
    for (int i = 0; i < nb; i++) begin
      if (gap && i > 0) begin wvalid = 1'b0; @(posedge clk); #1; end
      wdata = wbuf[i]; wstrb = strb; wlast = (i == last_idx); wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 50) begin n++; @(negedge clk); end
      if (!wready) chk("w_hs_timeout", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_go();
    int n = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && n < 50) begin n++; @(negedge clk); end
    if (!bvalid) chk("b_hs_timeout", bvalid, 1);
    b_resp = bresp; b_id = bid;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  // Collects one read burst; toggle drives rready 1,0,1,0... from the first beat.
  task automatic r_go(input int len, input bit toggle);
    bit ph = 1'b1, held = 1'b0;
    logic [31:0] sd; logic sl; logic [1:0] sr;
    beats = 0; nlast = 0; nstall = 0; stall_bad = 0; gaps = 0; lat = -1; last_at = -1;
    for (int cyc = 0; cyc < 600 && beats <= len; cyc++) begin
      rready = toggle ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      if (rvalid) begin
        if (lat < 0) lat = cyc;
        if (held && (rdata !== sd || rlast !== sl || rresp !== sr)) stall_bad++;
        if (rready) begin
          rbuf[beats] = rdata; rrsp[beats] = rresp; rid_got = rid;
          if (rlast) begin nlast++; last_at = beats; end
          beats++; held = 1'b0;
        end else begin
          held = 1'b1; sd = rdata; sl = rlast; sr = rresp; nstall++;
        end
      end else if (beats > 0) gaps++;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (beats != len + 1) chk("r_beats", beats, len + 1);
    @(negedge clk); post_rv = rvalid;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = INCR; awvalid = 1'b1;
    arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = INCR; arvalid = 1'b0;
    wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 0; rready = 0;

    // Reset state, and readies held low for the first cycle after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outputs", {awready, arready, wready, bvalid, rvalid, rlast, bresp, rresp,
                        bid, rid, buser, ruser}, 20'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_first_cycle", {awready, arready}, 2'b00);
    @(posedge clk); #1 awvalid = 1'b0;

    // Simultaneous AW/AR: write first after reset, then read wins the next tie.
    arid = 4'd1; araddr = 32'h40; arlen = 0; arburst = INCR; arsize = 3'd2; arvalid = 1'b1;
    wbuf[0] = 32'h1111;
    aw_go(4'd2, 32'h40, 0, INCR, 3'd2);
    chk("tie_write_first", aw_wait, 0);
    w_go(1, 0, 4'hF, 1'b0);
    b_go();
    awid = 4'd2; awaddr = 32'h44; awlen = 0; awburst = INCR; awsize = 3'd2; awvalid = 1'b1;
    ar_go(4'd1, 32'h40, 0, INCR, 3'd2);
    chk("tie_read_next", ar_wait, 0);
    awvalid = 1'b0;
    r_go(0, 1'b0);
    chk("tie_rdata", rbuf[0], 32'h1111);

    // 4-beat INCR write with gaps, read back.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    aw_go(4'd3, 32'h10, 3, INCR, 3'd2);
    w_go(4, 3, 4'hF, 1'b1);
    b_go();
    chk("t1_bresp_bid", {b_resp, b_id}, {2'b00, 4'd3});
    ar_go(4'd5, 32'h10, 3, INCR, 3'd2);
    r_go(3, 1'b0);
    chk("t1_latency", lat, 0);
    chk("t1_rdata", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, {32'd1, 32'd2, 32'd3, 32'd4});
    chk("t1_rlast", {last_at[7:0], nlast[7:0]}, {8'd3, 8'd1});
    chk("t1_rresp_rid", {rrsp[0], rrsp[1], rrsp[2], rrsp[3], rid_got}, {8'h00, 4'd5});

    // Byte strobes.
    wbuf[0] = 32'hAABBCCDD;
    aw_go(4'd4, 32'h0, 0, INCR, 3'd2); w_go(1, 0, 4'hF, 1'b0); b_go();
    wbuf[0] = 32'h11223344;
    aw_go(4'd4, 32'h0, 0, INCR, 3'd2); w_go(1, 0, 4'b0101, 1'b0); b_go();
    ar_go(4'd4, 32'h0, 0, INCR, 3'd2); r_go(0, 1'b0);
    chk("t2_strobe", rbuf[0], 32'hAA22CC44);

    // 8-beat read with rready toggling, then at full rate.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hA0 + 32'(i);
    aw_go(4'd6, 32'h100, 7, INCR, 3'd2); w_go(8, 7, 4'hF, 1'b0); b_go();
    ar_go(4'd6, 32'h100, 7, INCR, 3'd2); r_go(7, 1'b1);
    ok = 0;
    for (int i = 0; i < 8; i++) if (rbuf[i] === 32'hA0 + 32'(i)) ok++;
    chk("t4_stall_data", ok, 8);
    chk("t4_stall_stable", stall_bad, 0);
    chk("t4_stall_count", nstall, 7);
    chk("t4_rlast_once", {last_at[7:0], nlast[7:0]}, {8'd7, 8'd1});
    ar_go(4'd6, 32'h100, 7, INCR, 3'd2); r_go(7, 1'b0);
    chk("t4_no_bubble", {lat[7:0], gaps[7:0]}, 16'h0);
    chk("t4_rvalid_drop", post_rv, 1'b0);

    // Error bursts.
    ar_go(4'd7, 32'h100, 3, WRAP, 3'd2); r_go(3, 1'b0);
    ok = 0;
    for (int i = 0; i < 4; i++) if (rrsp[i] === 2'b10 && rbuf[i] === 32'h0) ok++;
    chk("t5_wrap_read", ok, 4);
    ar_go(4'd8, 32'h100, 1, INCR, 3'd0); r_go(1, 1'b0);
    ok = 0;
    for (int i = 0; i < 2; i++) if (rrsp[i] === 2'b10 && rbuf[i] === 32'h0) ok++;
    chk("t5_size_read", ok, 2);
    wbuf[0] = 32'hDEAD; wbuf[1] = 32'hBEEF;
    aw_go(4'd9, 32'h10, 1, WRAP, 3'd2); w_go(2, 1, 4'hF, 1'b0); b_go();
    chk("t5_wrap_bresp", b_resp, 2'b10);
    aw_go(4'd9, 32'h18, 0, INCR, 3'd0); w_go(1, 0, 4'hF, 1'b0); b_go();
    chk("t5_size_bresp", b_resp, 2'b10);
    ar_go(4'd9, 32'h10, 3, INCR, 3'd2); r_go(3, 1'b0);
    chk("t5_ram_kept", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]}, {32'd1, 32'd2, 32'd3, 32'd4});
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h300 + 32'(i);
    aw_go(4'd10, 32'h300, 3, INCR, 3'd2); w_go(4, 1, 4'hF, 1'b0); b_go();
    chk("t5_early_wlast", {b_resp, b_id}, {2'b10, 4'd10});

    // Reset during beat 2 of a 4-beat write.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hEE;
    aw_go(4'd11, 32'h200, 3, INCR, 3'd2); w_go(4, 3, 4'hF, 1'b0); b_go();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h51 + 32'(i);
    aw_go(4'd12, 32'h200, 3, INCR, 3'd2); w_go(2, 3, 4'hF, 1'b0);
    wdata = wbuf[2]; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    chk("t6_rst_immediate", {awready, arready, wready, bvalid, rvalid, rlast}, 6'h0);
    @(posedge clk); #1 wvalid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    ar_go(4'd13, 32'h200, 3, INCR, 3'd2); r_go(3, 1'b0);
    chk("t6_partial_burst", {rbuf[0], rbuf[1], rbuf[2], rbuf[3]},
        {32'h51, 32'h52, 32'hEE, 32'hEE});
    chk("t6_resp_after_rst", {rrsp[0], rid_got}, {2'b00, 4'd13});

    // INCR wraps from the last index to 0; upper address bits are ignored.
    wbuf[0] = 32'h77; wbuf[1] = 32'h88;
    aw_go(4'd1, 32'hFFC, 1, INCR, 3'd2); w_go(2, 1, 4'hF, 1'b0); b_go();
    ar_go(4'd1, 32'h1000, 0, INCR, 3'd2); r_go(0, 1'b0);
    chk("wrap_index0", rbuf[0], 32'h88);
    ar_go(4'd1, 32'hFFC, 0, INCR, 3'd2); r_go(0, 1'b0);
    chk("wrap_last_index", rbuf[0], 32'h77);

    // FIXED burst keeps writing the same word.
    wbuf[0] = 32'h5; wbuf[1] = 32'h6;
    aw_go(4'd2, 32'h400, 1, FIXED, 3'd2); w_go(2, 1, 4'hF, 1'b0); b_go();
    ar_go(4'd2, 32'h400, 1, INCR, 3'd2); r_go(1, 1'b0);
    chk("fixed_write", {rbuf[0], buser, ruser}, {32'h6, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
